uart_frame_tx: RTL and testbench
================================

Name: uart_frame_tx

Overview:
Transmit back-end that sits directly downstream of the LSU's `uart_out` port. It accepts 10-bit pre-framed UART words from the LSU store path and buffers them in a small FIFO. It then serialises each word LSB-first on a single line, pacing bits with an internal baud divider. It reports FIFO full/empty, busy and frame-done status back to the LSU/pipeline so stores to the UART can stall or poll.

Parameters:
- `CLK_DIV`, default 16: clock cycles per serial bit; legal range ≥2.
- `DEPTH`, default 4: FIFO entries; must be a power of 2, ≥2.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low; clears all state immediately.
- `frame_in`  in  10  frame from LSU: [0] start bit, [8:1] data LSB-first, [9] stop bit; transmitted as-is, not checked.
- `wr_en`  in  1  push `frame_in` this cycle.
- `Ff`  out  1  FIFO full.
- `Fe`  out  1  FIFO empty.
- `ovf`  out  1  one-cycle pulse: a push was dropped because the FIFO was full.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  a frame is being shifted.
- `tx_clk`  out  1  one-cycle pulse at the end of each bit period.
- `done_t`  out  1  one-cycle pulse when the last bit period of a frame completes.

Behaviour:
- Reset (`rst`=0, asynchronous): `tx`=1, `busy`=0, `Ff`=0, `Fe`=1, `ovf`=0, `tx_clk`=0, `done_t`=0. FIFO pointers, occupancy count, baud counter and bit index are all cleared.
- Reset mid-frame aborts the frame; `tx` goes high at once. Frames still in the FIFO are discarded.
- FIFO:
  - Occupancy `count` is 0..DEPTH. `Ff` = (count==DEPTH) and `Fe` = (count==0); both are registered.
  - Pointers are log2(DEPTH) bits and wrap naturally.
- Push rule: a push is accepted on a rising edge when `wr_en`=1 and `Ff`=0, as `Ff` stood before that edge.
  - `wr_en`=1 with `Ff`=1: the frame is dropped and `ovf`=1 for the next cycle. This holds even if a pop occurs on the same edge.
- Simultaneous accepted push and pop: `count` is unchanged and both pointers advance.
- FSM states: IDLE, SHIFT.
- IDLE:
  - `tx`=1, `busy`=0.
  - On an edge where `Fe`=0: pop the head into the 10-bit shift register, load `tx`←head[0], clear the baud counter and bit index, set `busy`=1, go to SHIFT.
  - A frame pushed on edge E therefore appears on `tx` after edge E+1 (one-cycle latency).
- SHIFT:
  - The baud counter counts 0..CLK_DIV-1.
  - At count CLK_DIV-1: `tx_clk` pulses for the following cycle, the counter wraps to 0 and the bit index increments.
  - If index<9: shift right and drive `tx`←next bit.
  - After the 10th bit period (index 9 expires): `done_t` pulses for the following cycle, coincident with `tx_clk`.
    - If `Fe`=0 at that edge: pop the next frame immediately, with no idle gap; stay in SHIFT with `busy`=1 and `tx`←new head[0].
    - Otherwise: go to IDLE, `tx`=1, `busy`=0.
- Each bit is held exactly CLK_DIV cycles. A frame occupies exactly 10·CLK_DIV cycles.
- `tx_clk` pulses only in SHIFT; it does not run in IDLE.
- Pushes during SHIFT never disturb the frame in flight.

Test Plan:
1. Reset then idle, with `CLK_DIV`=4 and `DEPTH`=4 for all tests: hold `rst`=0 for 3 cycles, then release and run 20 cycles with no push → `tx`=1, `Fe`=1, `Ff`=0, `busy`=0; no `tx_clk` or `done_t` pulse.
2. Single frame: push `frame_in`=0x34A (byte 0xA5) at edge E → from E+1, `tx` = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. `tx_clk` pulses every 4 cycles. `done_t` pulses once at E+41. `busy` falls and `tx`=1 afterwards.
3. Back-to-back: push 0x34A and 0x3FE on consecutive edges → the second start bit follows the first stop bit with no idle cycle. Two `done_t` pulses arrive exactly 40 cycles apart.
4. Overflow: while the first frame shifts, push 5 more frames → `Ff`=1 after the 4th buffered push. The 5th push is dropped with one `ovf` pulse. Exactly 5 frames total appear on `tx`, in order.
5. Full with simultaneous push/pop: with `Ff`=1, assert `wr_en` on the edge where the FSM pops → push dropped, `ovf`=1, `count` becomes DEPTH-1, `Ff` deasserts.
6. Reset mid-frame: assert `rst` low during bit 3 of a frame, asynchronously and between clock edges → `tx`=1 and `busy`=0 immediately. After release, `Fe`=1 and no residual bits are sent.

Source files
------------

// File: rtl/uart_frame_tx.sv
// UART transmit back-end: buffers pre-framed 10-bit words from the LSU in a small FIFO
// and shifts each one out LSB-first. Bit timing comes from an internal baud divider.
module uart_frame_tx #(
    parameter int CLK_DIV = 16,
    parameter int DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] frame_in,
    input  logic       wr_en,
    output logic       Ff,
    output logic       Fe,
    output logic       ovf,
    output logic       tx,
    output logic       busy,
    output logic       tx_clk,
    output logic       done_t
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLK_DIV);

    localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
    localparam logic [3:0]    LAST_BIT = 4'd9;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [9:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [9:0]    head;

    logic [0:0]    state;
    logic [9:0]    shreg;
    logic [BW-1:0] baud;
    logic [3:0]    bit_idx;

    logic push;
    logic pop;
    logic bit_end;
    logic frame_end;

    assign head      = mem[rd_ptr];
    assign push      = wr_en && !Ff;
    assign bit_end   = (state == ST_SHIFT) && (baud == BAUD_MAX);
    assign frame_end = bit_end && (bit_idx == LAST_BIT);
    // A new frame is taken either from idle or straight after a stop bit, so frames chain with no gap.
    assign pop       = !Fe && ((state == ST_IDLE) || frame_end);

    // The shift register idles at all ones, so its LSB doubles as the line driver.
    assign tx   = shreg[0];
    assign busy = (state == ST_SHIFT);

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (!push && pop) begin
            count_next = count - CW'(1);
        end
    end

    // NOTE: the storage array has no reset; only pointers and count define what is valid,
    // which keeps it mappable onto plain RAM/register-file cells.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= frame_in;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            Ff     <= 1'b0;
            Fe     <= 1'b1;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_next;
            Ff    <= (count_next == COUNT_FULL);
            Fe    <= (count_next == '0);
            ovf   <= wr_en && Ff;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            shreg   <= '1;
            baud    <= '0;
            bit_idx <= '0;
            tx_clk  <= 1'b0;
            done_t  <= 1'b0;
        end else begin
            tx_clk <= 1'b0;
            done_t <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        shreg   <= head;
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bit_end) begin
                        tx_clk <= 1'b1;
                        baud   <= '0;
                        if (bit_idx == LAST_BIT) begin
                            done_t  <= 1'b1;
                            bit_idx <= '0;
                            if (pop) begin
                                shreg <= head;
                            end else begin
                                shreg <= '1;
                                state <= ST_IDLE;
                            end
                        end else begin
                            shreg   <= {1'b1, shreg[9:1]};
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench for uart_frame_tx: the stimulus queues the frames it expects to see.
// A negedge monitor rebuilds each frame from the tx line and checks bit timing.
module tb_uart_frame_tx;

    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] frame_in = '0;
    logic       wr_en = 1'b0;
    logic       Ff, Fe, ovf, tx, busy, tx_clk, done_t;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [9:0] exp_q [$];

    // monitor state
    bit          in_frame = 0;
    bit          ended;
    bit          pat_ok;
    int          k;
    logic [39:0] samp;
    int          frames_seen = 0;
    int          stray_cnt   = 0;
    int          done_cnt    = 0;
    int          ovf_cnt     = 0;
    int          last_done   = 0;
    int          prev_done   = 0;

    uart_frame_tx #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .frame_in(frame_in), .wr_en(wr_en),
        .Ff(Ff), .Fe(Fe), .ovf(ovf), .tx(tx), .busy(busy),
        .tx_clk(tx_clk), .done_t(done_t)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] mk(input logic [7:0] d);
        return {1'b1, d, 1'b0};
    endfunction

    task automatic finish_frame();
        logic [9:0] f;
        logic [9:0] e;
        bit hold_ok;
        hold_ok = 1;
        for (int i = 0; i < 10; i++) f[i] = samp[4*i];
        for (int i = 0; i < 40; i++) if (samp[i] !== samp[(i/4)*4]) hold_ok = 0;
        check("bit_hold", 32'(hold_ok), 1);
        check("tick_pattern", 32'(pat_ok), 1);
        check("done_at_frame_end", {30'd0, tx_clk, done_t}, 32'h3);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL frame_unexpected: got 0x%0h, expected no frame", f);
        end else begin
            e = exp_q.pop_front();
            check("frame_data", 32'(f), 32'(e));
        end
    endtask

    // Monitor: one sample per negedge; a frame starts on the first low tx seen while idle.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                in_frame = 0;
                continue;
            end
            if (done_t) begin
                done_cnt++;
                prev_done = last_done;
                last_done = cyc;
            end
            if (ovf) ovf_cnt++;
            ended = 0;
            if (in_frame) begin
                if (k == 40) begin
                    finish_frame();
                    in_frame = 0;
                    ended = 1;
                end else begin
                    samp[k] = tx;
                    if (tx_clk !== (k % 4 == 0) || done_t !== 1'b0) pat_ok = 0;
                    k++;
                end
            end
            if (!in_frame) begin
                if (tx === 1'b0) begin
                    in_frame = 1;
                    frames_seen++;
                    pat_ok = 1;
                    samp[0] = tx;
                    k = 1;
                end else if (!ended && (tx_clk || done_t)) begin
                    stray_cnt++;
                end
            end
        end
    end

    // Called at a negedge: presents a push for the next rising edge, returns at the negedge after it.
    task automatic push_cycle(input logic [9:0] f, input bit accept);
        wr_en    = 1'b1;
        frame_in = f;
        if (accept) exp_q.push_back(f);
        @(negedge clk);
    endtask

    task automatic stop_push();
        wr_en = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check(name, 32'(done_cnt >= target), 1);
    endtask

    initial begin
        int e;
        int e0;
        int d0;
        int o0;
        int f0;

        // 1: reset then idle
        @(negedge clk);
        #1;
        check("rst_tx", 32'(tx), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_Ff", 32'(Ff), 0);
        check("rst_Fe", 32'(Fe), 1);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_tx_clk", 32'(tx_clk), 0);
        check("rst_done_t", 32'(done_t), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_tx", 32'(tx), 1);
        check("idle_Fe", 32'(Fe), 1);
        check("idle_Ff", 32'(Ff), 0);
        check("idle_busy", 32'(busy), 0);
        check("idle_no_frames", 32'(frames_seen), 0);
        check("idle_no_pulses", 32'(stray_cnt + done_cnt), 0);

        // 2: single frame 0x34A
        d0 = done_cnt;
        push_cycle(10'h34A, 1);
        e = cyc;
        stop_push();
        wait_done(d0 + 1, 80, "t2_done_timeout");
        check("t2_done_cycle", 32'(last_done), 32'(e + 41));
        check("t2_busy_after", 32'(busy), 0);
        check("t2_tx_after", 32'(tx), 1);
        check("t2_Fe_after", 32'(Fe), 1);

        // 3: back-to-back frames
        d0 = done_cnt;
        push_cycle(10'h34A, 1);
        push_cycle(10'h3FE, 1);
        stop_push();
        wait_done(d0 + 2, 150, "t3_done_timeout");
        check("t3_done_spacing", 32'(last_done - prev_done), 40);
        check("t3_queue_drained", 32'(exp_q.size()), 0);
        repeat (3) @(negedge clk);

        // 4 + 5: overflow, then a dropped push on the pop edge while full
        d0 = done_cnt;
        o0 = ovf_cnt;
        push_cycle(mk(8'h11), 1);
        e0 = cyc;
        stop_push();
        repeat (2) @(negedge clk);
        push_cycle(mk(8'h22), 1);
        push_cycle(mk(8'h33), 1);
        push_cycle(mk(8'h44), 1);
        check("t4_not_full_at_3", 32'(Ff), 0);
        push_cycle(mk(8'h55), 1);
        check("t4_full_at_4", 32'(Ff), 1);
        check("t4_no_ovf_yet", 32'(ovf), 0);
        push_cycle(mk(8'h66), 0);
        check("t4_ovf_pulse", 32'(ovf), 1);
        check("t4_still_full", 32'(Ff), 1);
        stop_push();
        @(negedge clk);
        check("t4_ovf_one_cycle", 32'(ovf), 0);
        while (cyc < e0 + 40) @(negedge clk);
        push_cycle(mk(8'h77), 0);
        check("t5_ovf", 32'(ovf), 1);
        check("t5_Ff_clear", 32'(Ff), 0);
        check("t5_Fe", 32'(Fe), 0);
        check("t5_pop_edge", 32'(done_t), 1);
        stop_push();
        wait_done(d0 + 5, 300, "t4_done_timeout");
        check("t4_ovf_count", 32'(ovf_cnt - o0), 2);
        check("t4_queue_drained", 32'(exp_q.size()), 0);
        check("t4_idle_after", 32'(busy), 0);
        repeat (3) @(negedge clk);

        // 6: asynchronous reset during bit 3
        push_cycle(10'h34A, 1);
        e = cyc;
        push_cycle(mk(8'hC3), 1);
        stop_push();
        while (cyc < e + 14) @(negedge clk);
        check("t6_mid_frame", 32'(busy), 1);
        #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("t6_rst_tx", 32'(tx), 1);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_Fe", 32'(Fe), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        f0 = frames_seen;
        d0 = done_cnt;
        repeat (60) @(negedge clk);
        check("t6_Fe_after", 32'(Fe), 1);
        check("t6_tx_after", 32'(tx), 1);
        check("t6_busy_after", 32'(busy), 0);
        check("t6_no_residual", 32'(frames_seen - f0), 0);
        check("t6_no_done", 32'(done_cnt - d0), 0);
        check("stray_pulses", 32'(stray_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
